// File: rtl/imem_loader_pkg.sv
// Shared constants and state encoding for the boot-time instruction loader.
package imem_loader_pkg;

    localparam int IMEM_AW = 8;
    localparam int IMEM_DW = 16;
    localparam int BYTE_W  = 8;

    typedef enum logic [2:0] {
        IDLE,
        LO,
        HI,
        CSUM,
        DONE,
        ERROR
    } state_t;

    // States in which the loader is still consuming stream bytes.
    function automatic logic state_accepts(state_t s);
        return (s == IDLE) || (s == LO) || (s == HI) || (s == CSUM);
    endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream valid/ready handshake feeding the instruction loader.
interface imem_loader_if;
    import imem_loader_pkg::*;

    logic              in_valid;
    logic [BYTE_W-1:0] in_data;
    logic              in_ready;

    modport master (output in_valid, output in_data, input in_ready);
    modport slave  (input in_valid, input in_data, output in_ready);

endinterface

// File: rtl/imem_loader_word_packer.sv
// Pairs stream bytes into {hi, lo} instruction words and owns the single
// registered write stage towards the instruction memory.
module word_packer
    import imem_loader_pkg::*;
#(
    parameter int AW = IMEM_AW,
    parameter int DW = IMEM_DW
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              lo_en,
    input  logic              hi_en,
    input  logic [BYTE_W-1:0] data,
    input  logic [AW-1:0]     addr,
    output logic              we,
    output logic [AW-1:0]     waddr,
    output logic [DW-1:0]     wdata
);

    logic [BYTE_W-1:0] lo_q;

    // NOTE: registers are assigned with <= so every flop samples pre-edge
    // values; blocking here would let lo_q update before wdata reads it.
    always_ff @(posedge clk) begin
        if (rst) begin
            lo_q  <= '0;
            we    <= 1'b0;
            waddr <= '0;
            wdata <= '0;
        end else begin
            we <= hi_en;
            if (lo_en) begin
                lo_q <= data;
            end
            if (hi_en) begin
                waddr <= addr;
                wdata <= {data, lo_q};
            end
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: LEN byte, then low/high byte pairs written to instruction
// memory; holds the core in reset until the image is complete.
// Optional trailing checksum byte when IMEM_LOADER_CHECKSUM_EN is defined.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int AW = IMEM_AW,
    parameter int DW = IMEM_DW
) (
    input  logic          clk,
    input  logic          rst,
    imem_loader_if.slave  stream,
    input  logic          reload,
    output logic          imem_we,
    output logic [AW-1:0] imem_addr,
    output logic [DW-1:0] imem_wdata,
    output logic          core_rst_n,
    output logic          done,
    output logic          error
);

    state_t        state;
    logic [AW-1:0] idx;
    logic [AW-1:0] len;
    logic          accept;
    logic          lo_acc;
    logic          hi_acc;
    logic          last_word;

    // Ready is forced low during reset so the source never sees a stale state.
    assign stream.in_ready = !rst && state_accepts(state);
    assign accept          = stream.in_valid && stream.in_ready;
    assign lo_acc          = accept && (state == LO);
    assign hi_acc          = accept && (state == HI);
    assign last_word       = (idx == len);

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [BYTE_W-1:0] csum;
    logic [BYTE_W-1:0] csum_next;

    assign csum_next = csum + stream.in_data;

    // Running sum restarts with the LEN byte and covers every byte after it.
    always_ff @(posedge clk) begin
        if (rst) begin
            csum  <= '0;
            error <= 1'b0;
        end else begin
            if (accept) begin
                csum <= (state == IDLE) ? stream.in_data : csum_next;
            end
            error <= (state == ERROR) && !reload;
        end
    end
`else
    assign error = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            idx        <= '0;
            len        <= '0;
            core_rst_n <= 1'b0;
            done       <= 1'b0;
        end else begin
            done       <= (state == DONE) && !reload;
            core_rst_n <= (state == DONE) && !reload;
            case (state)
                IDLE: begin
                    idx <= '0;
                    if (accept) begin
                        len   <= AW'(stream.in_data);
                        state <= LO;
                    end
                end
                LO: begin
                    if (accept) begin
                        state <= HI;
                    end
                end
                HI: begin
                    if (accept) begin
                        idx <= idx + AW'(1);
`ifdef IMEM_LOADER_CHECKSUM_EN
                        state <= last_word ? CSUM : LO;
`else
                        state <= last_word ? DONE : LO;
`endif
                    end
                end
`ifdef IMEM_LOADER_CHECKSUM_EN
                CSUM: begin
                    if (accept) begin
                        state <= (csum_next == '0) ? DONE : ERROR;
                    end
                end
`endif
                DONE, ERROR: begin
                    if (reload) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    word_packer #(
        .AW (AW),
        .DW (DW)
    ) u_word_packer (
        .clk   (clk),
        .rst   (rst),
        .lo_en (lo_acc),
        .hi_en (hi_acc),
        .data  (stream.in_data),
        .addr  (idx),
        .we    (imem_we),
        .waddr (imem_addr),
        .wdata (imem_wdata)
    );

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: expected writes are queued at each HI
// handshake and popped when the DUT pulses imem_we.
module tb_imem_loader;
    import imem_loader_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        reload = 1'b0;
    logic        imem_we;
    logic [7:0]  imem_addr;
    logic [15:0] imem_wdata;
    logic        core_rst_n;
    logic        done;
    logic        error;

    imem_loader_if bus();

    imem_loader dut (
        .clk        (clk),
        .rst        (rst),
        .stream     (bus),
        .reload     (reload),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .core_rst_n (core_rst_n),
        .done       (done),
        .error      (error)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_mis = 0;
    int          n_writes = 0;
    logic [23:0] sb[$];
    logic [15:0] img[$];
    logic [23:0] drv_exp = '0;
    logic [23:0] exp_w;
    bit          mon_en = 1'b0;
    bit          drv_is_hi = 1'b0;
    bit          pend_we = 1'b0;

    // Write monitor: imem_we must follow exactly the HI handshakes.
    always begin
        @(negedge clk);
        #1;
        if (mon_en) begin
            n_cmp++;
            if (imem_we !== pend_we) begin
                n_mis++;
                $display("FAIL we_timing: imem_we=%b expected=%b at t=%0t", imem_we, pend_we, $time);
            end
            if (imem_we === 1'b1) begin
                n_writes++;
                n_cmp++;
                if (sb.size() == 0) begin
                    n_mis++;
                    $display("FAIL unexpected_write: addr=%h data=%h, expected no write", imem_addr, imem_wdata);
                end else begin
                    exp_w = sb.pop_front();
                    if ({imem_addr, imem_wdata} !== exp_w) begin
                        n_mis++;
                        $display("FAIL write_data: addr=%h data=%h, expected addr=%h data=%h",
                                 imem_addr, imem_wdata, exp_w[23:16], exp_w[15:0]);
                    end
                end
            end
            pend_we = bus.in_valid && bus.in_ready && drv_is_hi && !rst;
            if (pend_we) sb.push_back(drv_exp);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic send_byte(input logic [7:0] b, input bit is_hi, input int gap);
        int wait_cyc = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        drv_is_hi    = is_hi;
        while (bus.in_ready !== 1'b1 && wait_cyc < 50) begin
            @(negedge clk);
            wait_cyc++;
        end
        n_cmp++;
        if (bus.in_ready !== 1'b1) begin
            n_mis++;
            $display("FAIL ready_timeout: in_ready=%b after %0d cycles, expected 1", bus.in_ready, wait_cyc);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        drv_is_hi    = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    // Streams img[] as one image, then checks the release timing.
    task automatic load_image(input int gap, input bit bad_csum, input bit expect_ok);
        logic [7:0] len_b;
        logic [7:0] sum;
        logic [7:0] csum_b;
        int         n;
        n     = img.size();
        len_b = 8'(n - 1);
        sum   = len_b;
        send_byte(len_b, 1'b0, gap);
        for (int i = 0; i < n; i++) begin
            sum = sum + img[i][7:0] + img[i][15:8];
            send_byte(img[i][7:0], 1'b0, gap);
            drv_exp = {8'(i), img[i]};
`ifdef IMEM_LOADER_CHECKSUM_EN
            send_byte(img[i][15:8], 1'b1, gap);
`else
            send_byte(img[i][15:8], 1'b1, (i == n - 1) ? 0 : gap);
`endif
        end
        csum_b = 8'(8'h00 - sum) + {7'b0, bad_csum};
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_byte(csum_b, 1'b0, 0);
`endif
        n_cmp++;
        if (done !== 1'b0 || core_rst_n !== 1'b0) begin
            n_mis++;
            $display("FAIL early_release: done=%b core_rst_n=%b csum=%h, expected 0/0", done, core_rst_n, csum_b);
        end
        @(negedge clk);
        n_cmp++;
        if (expect_ok && {done, core_rst_n, error, bus.in_ready} !== 4'b1100) begin
            n_mis++;
            $display("FAIL release: {done,core_rst_n,error,in_ready}=%b, expected 1100", {done, core_rst_n, error, bus.in_ready});
        end else if (!expect_ok && {done, core_rst_n, error, bus.in_ready} !== 4'b0010) begin
            n_mis++;
            $display("FAIL error_state: {done,core_rst_n,error,in_ready}=%b, expected 0010", {done, core_rst_n, error, bus.in_ready});
        end
    endtask

    task automatic do_reload();
        reload = 1'b1;
        @(negedge clk);
        reload = 1'b0;
        n_cmp++;
        if ({core_rst_n, done, error, bus.in_ready} !== 4'b0001) begin
            n_mis++;
            $display("FAIL reload: {core_rst_n,done,error,in_ready}=%b, expected 0001", {core_rst_n, done, error, bus.in_ready});
        end
    endtask

    task automatic check_sb_empty(input string name);
        n_cmp++;
        if (sb.size() != 0) begin
            n_mis++;
            $display("FAIL %s: %0d writes outstanding, expected 0", name, sb.size());
        end
    endtask

    task automatic check_reset_outputs(input string name);
        n_cmp++;
        if ({bus.in_ready, imem_we, imem_addr, imem_wdata, core_rst_n, done, error} !== 30'h0) begin
            n_mis++;
            $display("FAIL %s: ready=%b we=%b addr=%h data=%h core_rst_n=%b done=%b error=%b, expected all 0",
                     name, bus.in_ready, imem_we, imem_addr, imem_wdata, core_rst_n, done, error);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        mon_en = 1'b1;
        check_reset_outputs("reset_values");
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (bus.in_ready !== 1'b1) begin
            n_mis++;
            $display("FAIL ready_after_reset: in_ready=%b, expected 1", bus.in_ready);
        end
        // reload outside DONE/ERROR must be ignored
        reload = 1'b1;
        @(negedge clk);
        reload = 1'b0;
        n_cmp++;
        if ({bus.in_ready, core_rst_n, done} !== 3'b100) begin
            n_mis++;
            $display("FAIL reload_idle: {in_ready,core_rst_n,done}=%b, expected 100", {bus.in_ready, core_rst_n, done});
        end
    endtask

    task automatic test_basic();
        img = '{16'h0013, 16'h0193};
        load_image(0, 1'b0, 1'b1);
        check_sb_empty("basic_writes");
        n_cmp++;
        if ({imem_we, imem_addr, imem_wdata} !== {1'b0, 8'h01, 16'h0193}) begin
            n_mis++;
            $display("FAIL addr_data_hold: we=%b addr=%h data=%h, expected 0/01/0193", imem_we, imem_addr, imem_wdata);
        end
    endtask

    task automatic test_reload_gaps();
        do_reload();
        img = '{16'h0013, 16'h0193};
        load_image(3, 1'b0, 1'b1);
        check_sb_empty("gap_writes");
    endtask

    task automatic test_full_image();
        int start_writes;
        do_reload();
        img.delete();
        for (int i = 0; i < 256; i++) img.push_back({~8'(i), 8'(i)});
        start_writes = n_writes;
        load_image(0, 1'b0, 1'b1);
        repeat (4) @(negedge clk);
        n_cmp++;
        if (n_writes - start_writes != 256 || sb.size() != 0) begin
            n_mis++;
            $display("FAIL full_image: writes=%0d outstanding=%0d, expected 256/0", n_writes - start_writes, sb.size());
        end
    endtask

    task automatic test_rst_midload();
        do_reload();
        send_byte(8'h01, 1'b0, 0);
        send_byte(8'hEF, 1'b0, 0);
        drv_exp = {8'h00, 16'hBEEF};
        send_byte(8'hBE, 1'b1, 0);
        send_byte(8'h34, 1'b0, 0);
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("midload_reset");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_sb_empty("midload_writes");
        img = '{16'hCAFE, 16'h0042, 16'h7777};
        load_image(1, 1'b0, 1'b1);
        check_sb_empty("post_reset_load");
    endtask

`ifdef IMEM_LOADER_CHECKSUM_EN
    task automatic test_checksum();
        do_reload();
        img = '{16'h1234};
        load_image(0, 1'b0, 1'b1);
        do_reload();
        load_image(0, 1'b1, 1'b0);
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({core_rst_n, done, error} !== 3'b001) begin
            n_mis++;
            $display("FAIL error_hold: {core_rst_n,done,error}=%b, expected 001", {core_rst_n, done, error});
        end
        do_reload();
        check_sb_empty("checksum_writes");
    endtask
`endif

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        test_reset();
        test_basic();
        test_reload_gaps();
        test_full_image();
        test_rst_midload();
`ifdef IMEM_LOADER_CHECKSUM_EN
        test_checksum();
`endif
        repeat (3) @(negedge clk);
        check_sb_empty("final_drain");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
